mprj_io_cfg_loader: RTL and testbench

- Serial configuration sequencer for the user GPIO pad array.
- Fetches one CFG_BITS configuration word per pad from the housekeeping register file (oeb, inp_dis, dm[2:0], etc.).
- Shifts the words MSB-first into the daisy-chained per-pad GPIO control blocks, then pulses a parallel load so all pads update at once.
- Sits between housekeeping and the GPIO control-block chain that drives the pad array's oeb/inp_dis/dm inputs.

---
 rtl/mprj_io_cfg_loader.sv | 125 ++++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader: fetches one config word per pad, shifts the words MSB-first
// into the GPIO control-block chain (highest pad first), then strobes a parallel load.
module mprj_io_cfg_loader #(
   parameter int TOTAL_PADS = 38,
   parameter int CFG_BITS   = 13,
   parameter int IDX_W      = 6,
   parameter int CLK_DIV    = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [IDX_W-1:0]    cfg_idx,
   input  logic [CFG_BITS-1:0] cfg_word,
   output logic                serial_clock,
   output logic                serial_data_out,
   output logic                serial_load
);
   localparam int BW = $clog2(CFG_BITS + 1);
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] FETCH    = 3'd1;
   localparam logic [2:0] SHIFT_LO = 3'd2;
   localparam logic [2:0] SHIFT_HI = 3'd3;
   localparam logic [2:0] LOAD     = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;
   localparam logic [DW-1:0]    DIV_RELOAD = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0]    BIT_LAST   = BW'(CFG_BITS - 1);
   localparam logic [IDX_W-1:0] PAD_LAST   = IDX_W'(TOTAL_PADS - 1);

   logic [2:0]          state;
   logic [IDX_W-1:0]    pad_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [DW-1:0]       div_cnt;
   logic [CFG_BITS-1:0] shreg;
   logic [CFG_BITS-1:0] shreg_next;
   logic                div_end;

   assign div_end    = div_cnt == '0;
   assign shreg_next = shreg << 1;

   // div_cnt reloads on every state change so each timed state lasts exactly CLK_DIV cycles
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         cfg_idx         <= '0;
         serial_clock    <= 1'b0;
         serial_data_out <= 1'b0;
         serial_load     <= 1'b0;
         pad_cnt         <= '0;
         bit_cnt         <= '0;
         div_cnt         <= DIV_RELOAD;
         shreg           <= '0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= DIV_RELOAD;
               if (start) begin
                  cfg_idx <= PAD_LAST;
                  pad_cnt <= PAD_LAST;
                  busy    <= 1'b1;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               shreg           <= cfg_word;
               bit_cnt         <= BIT_LAST;
               serial_data_out <= cfg_word[CFG_BITS-1];
               div_cnt         <= DIV_RELOAD;
               state           <= SHIFT_LO;
            end
            SHIFT_LO: begin
               if (div_end) begin
                  serial_clock <= 1'b1;
                  div_cnt      <= DIV_RELOAD;
                  state        <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_end) begin
                  serial_clock <= 1'b0;
                  shreg        <= shreg_next;
                  div_cnt      <= DIV_RELOAD;
                  if (bit_cnt != '0) begin
                     bit_cnt         <= bit_cnt - 1'b1;
                     serial_data_out <= shreg_next[CFG_BITS-1];
                     state           <= SHIFT_LO;
                  end else if (pad_cnt != '0) begin
                     pad_cnt <= pad_cnt - 1'b1;
                     cfg_idx <= pad_cnt - 1'b1;
                     state   <= FETCH;
                  end else begin
                     serial_load <= 1'b1;
                     state       <= LOAD;
                  end
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            LOAD: begin
               if (div_end) begin
                  serial_load <= 1'b0;
                  done        <= 1'b1;
                  div_cnt     <= DIV_RELOAD;
                  state       <= DONE;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               div_cnt <= DIV_RELOAD;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb_mprj_io_cfg_loader: directed bench for a 2-pad/3-bit/div-1 instance and a default instance.
module tb_mprj_io_cfg_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic       s_rstn = 1'b0, s_start = 1'b0, s_force = 1'b0;
   logic       s_busy, s_done, s_sclk, s_sdo, s_load;
   logic [5:0] s_idx;
   logic [2:0] s_word;

   logic        d_rstn = 1'b0, d_start = 1'b0;
   logic        d_busy, d_done, d_sclk, d_sdo, d_load;
   logic [5:0]  d_idx;
   logic [12:0] d_word;

   always_comb s_word = s_force ? 3'b111 : (s_idx == 6'd1 ? 3'b101 : 3'b011);
   always_comb d_word = 13'h1A5C ^ {7'b0, d_idx};

   mprj_io_cfg_loader #(.TOTAL_PADS(2), .CFG_BITS(3), .IDX_W(6), .CLK_DIV(1)) u_small (
      .clk(clk), .resetn(s_rstn), .start(s_start), .busy(s_busy), .done(s_done),
      .cfg_idx(s_idx), .cfg_word(s_word), .serial_clock(s_sclk),
      .serial_data_out(s_sdo), .serial_load(s_load)
   );

   mprj_io_cfg_loader u_dflt (
      .clk(clk), .resetn(d_rstn), .start(d_start), .busy(d_busy), .done(d_done),
      .cfg_idx(d_idx), .cfg_word(d_word), .serial_clock(d_sclk),
      .serial_data_out(d_sdo), .serial_load(d_load)
   );

   int s_rises = 0, s_load_n = 0, s_done_n = 0, s_busy_n = 0;
   logic s_prev = 1'b0;
   logic [63:0] s_bits = '0;
   logic [15:0] s_idx_hist = '0;
   logic [5:0]  s_idx_prev = '0;
   int d_rises = 0, d_load_n = 0, d_done_n = 0, d_busy_n = 0;
   logic d_prev = 1'b0;
   logic [63:0] d_bits = '0;

   // chain model: capture data on each rising serial_clock, count strobes and busy cycles
   always @(negedge clk) begin
      if (s_sclk && !s_prev) begin
         s_rises++;
         s_bits = {s_bits[62:0], s_sdo};
      end
      s_prev = s_sclk;
      if (s_load) s_load_n++;
      if (s_done) s_done_n++;
      if (s_busy) s_busy_n++;
      if (s_idx != s_idx_prev) s_idx_hist = {s_idx_hist[13:0], s_idx[1:0]};
      s_idx_prev = s_idx;
   end

   always @(negedge clk) begin
      if (d_sclk && !d_prev) begin
         d_rises++;
         d_bits = {d_bits[62:0], d_sdo};
      end
      d_prev = d_sclk;
      if (d_load) d_load_n++;
      if (d_done) d_done_n++;
      if (d_busy) d_busy_n++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_small(input bit use_force, input int second_start, output int cyc);
      @(negedge clk);
      s_start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         s_start = (cyc == second_start);
         s_force = use_force && cyc != 1 && cyc != 8;
      end while (!s_done && cyc < 200);
      s_start = 1'b0;
      s_force = 1'b0;
      #1;
   endtask

   initial begin
      int n, r0, l0, d0, b0, k;
      repeat (3) @(negedge clk);
      #1;
      check("rst_small_outputs", int'({s_busy, s_done, s_sclk, s_sdo, s_load, s_idx}), 0);
      check("rst_dflt_outputs", int'({d_busy, d_done, d_sclk, d_sdo, d_load, d_idx}), 0);
      @(negedge clk);
      s_rstn = 1'b1;
      d_rstn = 1'b1;

      r0 = s_rises; l0 = s_load_n; d0 = s_done_n; b0 = s_busy_n;
      run_small(1'b0, 0, n);
      check("basic_cycles_to_done", n, 16);
      check("basic_bits", int'(s_bits[5:0]), 6'b101011);
      check("basic_rises", s_rises - r0, 6);
      check("basic_load_cycles", s_load_n - l0, 1);
      check("basic_done_pulses", s_done_n - d0, 1);
      check("basic_busy_cycles", s_busy_n - b0, 16);
      check("fetch_idx_order", int'(s_idx_hist[3:0]), 4'b0100);

      run_small(1'b1, 0, n);
      check("word_change_outside_fetch_bits", int'(s_bits[5:0]), 6'b101011);

      r0 = s_rises; d0 = s_done_n;
      run_small(1'b0, 5, n);
      check("start_while_busy_rises", s_rises - r0, 6);
      check("start_while_busy_done", s_done_n - d0, 1);
      check("start_while_busy_cycles", n, 16);

      r0 = s_rises;
      s_start = 1'b1;
      @(negedge clk);
      check("start_in_done_ignored", int'(s_busy), 0);
      @(negedge clk);
      check("start_after_done_accepted", int'(s_busy), 1);
      s_start = 1'b0;
      n = 1;
      while (!s_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("restart_cycles", n, 16);
      check("restart_rises", s_rises - r0, 6);

      r0 = s_rises; l0 = s_load_n; d0 = s_done_n;
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      k = 0;
      do begin
         #1;
         k++;
         if (s_rises - r0 < 3) @(negedge clk);
      end while (s_rises - r0 < 3 && k < 100);
      check("midreset_third_rise_seen", s_rises - r0, 3);
      s_rstn = 1'b0;
      #1;
      check("midreset_async_outputs", int'({s_busy, s_done, s_sclk, s_sdo, s_load, s_idx}), 0);
      repeat (6) @(negedge clk);
      #1;
      check("midreset_no_load", s_load_n - l0, 0);
      check("midreset_no_done", s_done_n - d0, 0);
      s_rstn = 1'b1;
      run_small(1'b0, 0, n);
      check("after_reset_cycles", n, 16);
      check("after_reset_bits", int'(s_bits[5:0]), 6'b101011);

      r0 = d_rises; l0 = d_load_n; d0 = d_done_n; b0 = d_busy_n;
      @(negedge clk);
      d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      n = 1;
      while (!d_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("dflt_cycles_to_done", n, 3995);
      check("dflt_rises", d_rises - r0, 494);
      check("dflt_load_cycles", d_load_n - l0, 4);
      check("dflt_done_pulses", d_done_n - d0, 1);
      check("dflt_busy_cycles", d_busy_n - b0, 3995);
      check("dflt_pad0_last_word", int'(d_bits[12:0]), 13'h1A5C);
      check("dflt_pad1_word", int'(d_bits[25:13]), 13'h1A5D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
